// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word per request/ready
// handshake into the instruction register, and exposes decoded fields.
// The PC advances only when control signals retirement with pc_update.
module instr_fetch_unit #(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_en,
  input  logic             pc_update,
  input  logic             PC_MUX_sel,
  input  logic             PC_stall,
  input  logic [WIDTH-1:0] branch_target,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] instr,
  output logic [6:0]       opcode,
  output logic [2:0]       func3,
  output logic [6:0]       func7,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic             inst_valid,
  output logic             fetch_err,
  output logic             misalign_err
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic            pend_reg;
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] instr_reg;
  logic            valid_reg;
  logic            fetch_err_reg;
  logic            misalign_reg;

  logic upd_ok;     // accepted retire pulse (never in REQ, never while stalled)
  logic bad_tgt;    // branch target not word-aligned
  logic start;      // begin a fetch this cycle
  logic got;        // memory returned the word
  logic tmo;        // last allowed REQ cycle expired without ready

  assign upd_ok  = pc_update && !PC_stall && (state_reg != REQ);
  assign bad_tgt = PC_MUX_sel && (branch_target[1:0] != 2'b00);
  // A fetch_en that coincided with a retire is replayed one cycle later so
  // the request goes out at the updated PC.
  assign start   = (state_reg == IDLE) && !upd_ok && !PC_stall && (fetch_en || pend_reg);
  assign got     = (state_reg == REQ) && imem_ready;
  assign tmo     = (state_reg == REQ) && !imem_ready && (cnt_reg == CNT_LAST);

  // State register; reset drops imem_req immediately since it decodes state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic; a retire always returns the FSM to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = REQ;
      REQ:     if (got) state_next = HOLD;
               else if (tmo) state_next = IDLE;
      HOLD:    state_next = HOLD;
      default: state_next = IDLE;
    endcase
    if (upd_ok) state_next = IDLE;
  end

  // PC, instruction register, timeout counter and sticky error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg        <= RESET_PC;
      instr_reg     <= 32'h0000_0013;
      valid_reg     <= 1'b0;
      fetch_err_reg <= 1'b0;
      misalign_reg  <= 1'b0;
      cnt_reg       <= '0;
      pend_reg      <= 1'b0;
    end else begin
      pend_reg <= upd_ok && fetch_en;
      if ((state_reg == REQ) && !imem_ready && (cnt_reg != CNT_LAST))
        cnt_reg <= cnt_reg + 1'b1;
      else
        cnt_reg <= '0;
      if (got) begin
        instr_reg <= imem_rdata;
        valid_reg <= 1'b1;
      end
      if (tmo) fetch_err_reg <= 1'b1;
      if (upd_ok) begin
        valid_reg <= 1'b0;
        if (!PC_MUX_sel)  pc_reg <= pc_reg + WIDTH'(4);
        else if (bad_tgt) misalign_reg <= 1'b1;
        else              pc_reg <= branch_target;
      end
    end
  end

  assign imem_req     = (state_reg == REQ);
  assign imem_addr    = pc_reg;
  assign pc           = pc_reg;
  assign pc_plus4     = pc_reg + WIDTH'(4);
  assign instr        = instr_reg;
  assign opcode       = instr_reg[6:0];
  assign func3        = instr_reg[14:12];
  assign func7        = instr_reg[31:25];
  assign rd           = instr_reg[11:7];
  assign rs1          = instr_reg[19:15];
  assign rs2          = instr_reg[24:20];
  assign inst_valid   = valid_reg;
  assign fetch_err    = fetch_err_reg;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: fetched words go into a
// scoreboard queue when requested and are compared when inst_valid rises.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_en = 1'b0, pc_update = 1'b0, PC_MUX_sel = 1'b0, PC_stall = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc, pc_plus4, instr;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic [4:0]  rd, rs1, rs2;
  logic        inst_valid, fetch_err, misalign_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc = 32'h0;
  logic        prev_valid = 1'b0;

  instr_fetch_unit #(.WIDTH(32), .RESET_PC(32'h0), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .pc_update(pc_update),
    .PC_MUX_sel(PC_MUX_sel), .PC_stall(PC_stall), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .pc(pc), .pc_plus4(pc_plus4), .instr(instr),
    .opcode(opcode), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .inst_valid(inst_valid), .fetch_err(fetch_err), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Scoreboard monitor: every rising inst_valid must match the oldest queued word.
  always @(negedge clk) begin
    if (rst && inst_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("sb_instr", instr, e);
        chk("sb_opcode", {25'd0, opcode}, {25'd0, e[6:0]});
        chk("sb_func3", {29'd0, func3}, {29'd0, e[14:12]});
        chk("sb_func7", {25'd0, func7}, {25'd0, e[31:25]});
        chk("sb_rd", {27'd0, rd}, {27'd0, e[11:7]});
        chk("sb_rs1", {27'd0, rs1}, {27'd0, e[19:15]});
        chk("sb_rs2", {27'd0, rs2}, {27'd0, e[24:20]});
      end
    end
    prev_valid = inst_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a fetch; memory answers after `lat` wait cycles in REQ.
  task automatic do_fetch(input logic [31:0] word, input int lat);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    chk("req_high", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, exp_pc);
    sb.push_back(word);
    repeat (lat) tick();
    imem_rdata = word;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    chk("valid_set", {31'd0, inst_valid}, 32'd1);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic do_update(input logic sel, input logic [31:0] tgt);
    PC_MUX_sel = sel;
    branch_target = tgt;
    pc_update = 1'b1;
    tick();
    pc_update = 1'b0;
    if (!sel) exp_pc = exp_pc + 32'd4;
    else if (tgt[1:0] == 2'b00) exp_pc = tgt;
    chk("upd_pc", pc, exp_pc);
    chk("upd_pc4", pc_plus4, exp_pc + 32'd4);
    chk("upd_valid_clr", {31'd0, inst_valid}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h13);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_errs", {30'd0, fetch_err, misalign_err}, 32'd0);
    rst = 1'b1;
    tick();

    // Zero-wait fetch with field decode against known values
    do_fetch(32'h0020_80B3, 0);
    #4;
    chk("t1_opcode", {25'd0, opcode}, 32'h33);
    chk("t1_rd_rs1_rs2", {17'd0, rd, rs1, rs2}, {17'd0, 5'd1, 5'd1, 5'd2});
    #1;

    // Sequential PC advance with fetches
    for (int i = 0; i < 3; i++) begin
      do_update(1'b0, 32'h0);
      do_fetch(32'h0000_0013 + (i << 7) + ($urandom_range(0, 31) << 15), i + 1);
    end
    chk("t2_pc12", pc, 32'd12);

    // Branch, then misaligned branch
    do_update(1'b1, 32'h100);
    do_fetch(32'hFE21_8AE3, 2);
    do_update(1'b1, 32'h102);
    chk("t3_misalign", {31'd0, misalign_err}, 32'd1);

    // Ready on the last allowed cycle beats the timeout
    do_fetch(32'h0041_0093, 15);
    chk("ready_wins_no_err", {31'd0, fetch_err}, 32'd0);

    // pc_update and fetch_en together: fetch replays at new PC
    PC_MUX_sel = 1'b0;
    pc_update = 1'b1;
    fetch_en = 1'b1;
    tick();
    pc_update = 1'b0;
    fetch_en = 1'b0;
    exp_pc = exp_pc + 32'd4;
    chk("pend_pc", pc, exp_pc);
    chk("pend_no_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("pend_req", {31'd0, imem_req}, 32'd1);
    chk("pend_addr", imem_addr, exp_pc);
    sb.push_back(32'h0063_0333);
    imem_rdata = 32'h0063_0333;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;

    // PC wraparound
    do_update(1'b1, 32'hFFFF_FFFC);
    do_update(1'b0, 32'h0);
    chk("wrap_pc", pc, 32'h0);

    // Timeout: memory never answers
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    begin
      int n;
      n = 0;
      while (imem_req && n < 40) begin
        tick();
        n++;
      end
      chk("tmo_cycles", n, 32'd16);
    end
    chk("tmo_err", {31'd0, fetch_err}, 32'd1);
    chk("tmo_req", {31'd0, imem_req}, 32'd0);
    chk("tmo_valid", {31'd0, inst_valid}, 32'd0);
    // Late ready after timeout is ignored
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;

    // Stall blocks update and fetch start
    PC_stall = 1'b1;
    pc_update = 1'b1;
    fetch_en = 1'b1;
    tick();
    pc_update = 1'b0;
    fetch_en = 1'b0;
    tick();
    chk("stall_pc", pc, exp_pc);
    chk("stall_no_req", {31'd0, imem_req}, 32'd0);
    PC_stall = 1'b0;
    do_fetch(32'h0085_0513, 1);

    // Async reset in the middle of REQ
    do_update(1'b0, 32'h0);
    fetch_en = 1'b1;
    tick();
    fetch_en = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_pc", pc, 32'h0);
    exp_pc = 32'h0;
    #6;
    rst = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    chk("arst_instr", instr, 32'h13);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_errs", {30'd0, fetch_err, misalign_err}, 32'd0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Multi-cycle instruction fetch stage directly upstream of the control unit. It owns the program counter and issues a request/ready handshake to instruction memory. It latches the returned word into an instruction register and presents the decoded opcode/func3/func7/register fields to control. PC advances only on an explicit retire pulse from control, using PC_MUX_sel and PC_stall.

Parameters:
WIDTH, 32, datapath/address width (only 32 supported)
RESET_PC, 32'h0000_0000, PC value after reset (must be word-aligned)
TIMEOUT, 16, max cycles waiting for imem_ready before abort (>=2)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
fetch_en  input  1  pulse from control (IF state): start fetch at current PC
pc_update  input  1  pulse from control: instruction retired, advance PC
PC_MUX_sel  input  1  0 = PC+4, 1 = branch_target
PC_stall  input  1  blocks pc_update and fetch start while high
branch_target  input  WIDTH  jump/branch target from ALU
imem_req  output  1  memory request, held until imem_ready
imem_addr  output  WIDTH  fetch address (= pc while imem_req)
imem_rdata  input  WIDTH  instruction word, valid with imem_ready
imem_ready  input  1  memory completion strobe
pc  output  WIDTH  current PC
pc_plus4  output  WIDTH  pc + 4 (for JAL/JALR link)
instr  output  WIDTH  instruction register
opcode  output  7  instr[6:0]
func3  output  3  instr[14:12]
func7  output  7  instr[31:25]
rd, rs1, rs2  output  5 each  instr[11:7], instr[19:15], instr[24:20]
inst_valid  output  1  instr holds a fetched, unretired instruction
fetch_err  output  1  sticky: fetch timed out
misalign_err  output  1  sticky: branch_target[1:0] != 0 on update

Behaviour:
- Reset (rst low, async): pc=RESET_PC, instr=32'h0000_0013 (NOP), imem_req=0, inst_valid=0, fetch_err=0, misalign_err=0, state=IDLE, timeout counter=0. imem_req drops immediately with rst, not at next edge. Any imem_ready after reset release with no request pending is ignored.
- States: IDLE, REQ, HOLD.
- IDLE: on fetch_en && !PC_stall -> REQ; fetch_en with PC_stall=1 is dropped (control re-pulses).
- REQ: imem_req=1, imem_addr=pc, counter increments each cycle.
  - On imem_ready: instr<=imem_rdata, inst_valid<=1, counter<=0, -> HOLD. Minimum latency is 1 cycle after entering REQ, i.e. a zero-wait memory gives inst_valid 2 edges after fetch_en.
  - If counter reaches TIMEOUT-1 without imem_ready: fetch_err<=1, imem_req<=0, instr unchanged, -> IDLE.
  - imem_ready and timeout in the same cycle: ready wins.
- HOLD: instr and fields stable; fetch_en ignored.
- Fields are combinational slices of instr.
- pc_update (any state except REQ; ignored in REQ):
  - If PC_stall=1, the update is ignored entirely.
  - Otherwise inst_valid<=0, state -> IDLE.
  - PC_MUX_sel=0: pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC -> 0).
  - PC_MUX_sel=1 with branch_target[1:0]==0: pc<=branch_target.
  - PC_MUX_sel=1 with branch_target[1:0]!=0: misalign_err<=1, pc unchanged.
- pc_update and fetch_en in the same cycle (IDLE/HOLD): PC updates; fetch starts next cycle -> REQ at the new PC. The fetch_en is treated as pending for exactly one cycle and is still subject to PC_stall in that cycle.
- pc_plus4 = pc+4, combinational.
- Errors are cleared only by reset.

Test Plan:
1. Reset, fetch_en, memory ready 1 cycle later returning 32'h0020_80B3 -> imem_addr=0, inst_valid=1, opcode=7'h33, func3=0, func7=0, rd=1, rs1=1, rs2=2.
2. pc_update with PC_MUX_sel=0 three times, each followed by a fetch -> pc 4, 8, 12; imem_addr matches pc; inst_valid cleared on each update.
3. PC_MUX_sel=1, branch_target=0x100 -> pc=0x100. Then branch_target=0x102 -> misalign_err=1 and pc stays 0x100.
4. Memory never asserts ready, TIMEOUT=16 -> fetch_err=1 on the 16th REQ cycle, imem_req=0, state IDLE, inst_valid=0.
5. PC_stall=1 with pc_update and fetch_en -> pc unchanged, no imem_req. Release stall and re-pulse -> normal fetch.
6. Assert rst low mid-REQ -> imem_req=0 immediately, pc=RESET_PC. imem_ready arriving after release -> instr stays 0x13, inst_valid=0.
